// File: rtl/package_settings.sv
// package_settings
// Project-wide data-path settings shared by the ADC front end and the
// downstream filter chain.
//   SIZE_ADC_DATA : width of one ADC sample in bits (unsigned).
package package_settings;

   localparam int SIZE_ADC_DATA = 12;

endpackage

// File: rtl/pulse_gen_parameters.sv
// pulse_gen_parameters
// Defaults, state encoding and arithmetic helpers for the synthetic ADC
// pulse generator.
//   RISE_SHIFT_DEFAULT  : log2 of rise length in samples.
//   DECAY_SHIFT_DEFAULT : exponential decay shift, matched to filter M.
//   BASELINE_DEFAULT    : pedestal added to every output sample.
//   pulse_state_t       : IDLE / RISE / DECAY.
//   sat_add()           : level + addend clamped to the ADC full scale.
package pulse_gen_parameters;

   import package_settings::*;

   localparam int RISE_SHIFT_DEFAULT  = 2;
   localparam int DECAY_SHIFT_DEFAULT = 4;
   localparam logic [SIZE_ADC_DATA-1:0] BASELINE_DEFAULT = '0;

   // Internal level carries one extra bit so a pile-up rise can overshoot
   // full scale without wrapping before it snaps to the clamped target.
   localparam int LEVEL_W  = SIZE_ADC_DATA + 1;
   localparam int PERIOD_W = 16;
   localparam int DROP_W   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RISE  = 2'd1,
      DECAY = 2'd2
   } pulse_state_t;

   function automatic logic [SIZE_ADC_DATA-1:0] sat_add(
      input logic [LEVEL_W-1:0]       level,
      input logic [SIZE_ADC_DATA-1:0] addend
   );
      logic [LEVEL_W:0] sum;
      sum = {1'b0, level} + {2'b00, addend};
      if (sum[LEVEL_W:SIZE_ADC_DATA] != '0) return '1;
      return sum[SIZE_ADC_DATA-1:0];
   endfunction

endpackage

// File: rtl/pulse_trigger_timer.sv
// pulse_trigger_timer
// Free-running down counter that produces the periodic auto-trigger.
//   clk, reset : rising-edge clock, synchronous active-high reset.
//   enable     : counter runs only while high; otherwise held at zero.
//   period     : interval in cycles; zero disables the strobe.
//   expire     : combinational strobe, high in the cycle the count is zero.
// The counter sits at zero while disabled, so enabling fires on the very
// next edge and then every 'period' edges after that.
module pulse_trigger_timer
   import pulse_gen_parameters::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   output logic                expire
);

   logic [PERIOD_W-1:0] count;

   always_comb begin
      expire = enable && (period != '0) && (count == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (!enable || period == '0) begin
         count <= '0;
      end else if (count == '0) begin
         count <= period - PERIOD_W'(1);
      end else begin
         count <= count - PERIOD_W'(1);
      end
   end

endmodule

// File: rtl/adc_pulse_generator.sv
// adc_pulse_generator
// Synthetic ADC source: a linear rise of 2^RISE_SHIFT samples followed by
// an exponential decay v -= v >> DECAY_SHIFT, one sample per clock.
//   clk, reset : rising-edge clock, synchronous active-high reset.
//   start      : single-cycle pulse request.
//   amplitude  : pulse height, captured when a trigger is accepted.
//   auto_en    : enables the periodic internal trigger.
//   period     : auto-trigger interval in cycles (0 = off).
//   adc_data   : registered sample, BASELINE + level clamped to full scale.
//   busy       : high while in RISE or DECAY.
//   pulse_mark : one cycle on each accepted trigger.
//   done       : one cycle on the edge that returns to IDLE.
//   dropped    : saturating count of triggers rejected during RISE.
//   fsm_state  : current state, for observation.
// Handshake: start is a one-cycle request with no ready; it is accepted in
// IDLE or DECAY and rejected (counted in dropped) in RISE. start and an
// auto-trigger on the same edge count as a single trigger.
module adc_pulse_generator
   import package_settings::*, pulse_gen_parameters::*;
#(
   parameter int                         RISE_SHIFT  = RISE_SHIFT_DEFAULT,
   parameter int                         DECAY_SHIFT = DECAY_SHIFT_DEFAULT,
   parameter logic [SIZE_ADC_DATA-1:0]   BASELINE    = BASELINE_DEFAULT
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [SIZE_ADC_DATA-1:0] amplitude,
   input  logic                     auto_en,
   input  logic [PERIOD_W-1:0]      period,
   output logic [SIZE_ADC_DATA-1:0] adc_data,
   output logic                     busy,
   output logic                     pulse_mark,
   output logic                     done,
   output logic [DROP_W-1:0]        dropped,
   output pulse_state_t             fsm_state
);

   localparam int RISE_CNT_W = RISE_SHIFT + 1;
   localparam logic [RISE_CNT_W-1:0] RISE_LAST = RISE_CNT_W'((1 << RISE_SHIFT) - 1);

   pulse_state_t             state;
   logic [LEVEL_W-1:0]       level;
   logic [LEVEL_W-1:0]       target;
   logic [SIZE_ADC_DATA-1:0] step;
   logic [RISE_CNT_W-1:0]    rise_cnt;

   logic                     auto_fire;
   logic                     trigger;
   logic [LEVEL_W-1:0]       rise_next;
   logic [LEVEL_W-1:0]       decay_amt;
   logic [LEVEL_W-1:0]       decay_next;

   pulse_trigger_timer u_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (auto_en),
      .period (period),
      .expire (auto_fire)
   );

   always_comb begin
      trigger    = start | auto_fire;
      rise_next  = level + {1'b0, step};
      decay_amt  = level >> DECAY_SHIFT;
      decay_next = level - decay_amt;
      fsm_state  = state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         level      <= '0;
         target     <= '0;
         step       <= '0;
         rise_cnt   <= '0;
         adc_data   <= BASELINE;
         busy       <= 1'b0;
         pulse_mark <= 1'b0;
         done       <= 1'b0;
         dropped    <= '0;
      end else begin
         pulse_mark <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  // The accepting edge already carries the first rise step.
                  target     <= {1'b0, amplitude};
                  step       <= amplitude >> RISE_SHIFT;
                  level      <= {1'b0, amplitude >> RISE_SHIFT};
                  adc_data   <= sat_add({1'b0, amplitude >> RISE_SHIFT}, BASELINE);
                  rise_cnt   <= RISE_CNT_W'(1);
                  state      <= RISE;
                  busy       <= 1'b1;
                  pulse_mark <= 1'b1;
               end else begin
                  adc_data <= sat_add(level, BASELINE);
                  busy     <= 1'b0;
               end
            end

            RISE: begin
               if (trigger && dropped != '1) begin
                  dropped <= dropped + DROP_W'(1);
               end
               busy <= 1'b1;
               if (rise_cnt >= RISE_LAST) begin
                  // Snap to the target so truncation in step never leaves a gap.
                  level    <= target;
                  adc_data <= sat_add(target, BASELINE);
                  state    <= DECAY;
               end else begin
                  level    <= rise_next;
                  adc_data <= sat_add(rise_next, BASELINE);
                  rise_cnt <= rise_cnt + RISE_CNT_W'(1);
               end
            end

            DECAY: begin
               if (trigger) begin
                  // Pile-up: hold the level this edge, then climb a full set
                  // of steps toward the summed, clamped target.
                  target     <= {1'b0, sat_add(level, amplitude)};
                  step       <= amplitude >> RISE_SHIFT;
                  rise_cnt   <= '0;
                  adc_data   <= sat_add(level, BASELINE);
                  state      <= RISE;
                  busy       <= 1'b1;
                  pulse_mark <= 1'b1;
               end else if (decay_amt == '0) begin
                  level    <= '0;
                  adc_data <= BASELINE;
                  state    <= IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  level    <= decay_next;
                  adc_data <= sat_add(decay_next, BASELINE);
                  busy     <= 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               level    <= '0;
               adc_data <= BASELINE;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_pulse_generator.sv
// tb_adc_pulse_generator
// Self-checking bench for adc_pulse_generator with default parameters
// (12-bit data, 4-sample rise, decay shift 4, zero baseline). Expected
// per-cycle words {done, busy, pulse_mark, adc_data} are queued when a
// scenario is set up and popped as the DUT produces each sample.
module tb_adc_pulse_generator;

   import pulse_gen_parameters::*;

   localparam int W = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] amplitude;
   logic        auto_en;
   logic [15:0] period;
   logic [11:0] adc_data;
   logic        busy;
   logic        pulse_mark;
   logic        done;
   logic [7:0]  dropped;
   pulse_state_t fsm_state;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got;
   logic [W-1:0] exp_v;
   int checks = 0;
   int errors = 0;

   adc_pulse_generator dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .amplitude  (amplitude),
      .auto_en    (auto_en),
      .period     (period),
      .adc_data   (adc_data),
      .busy       (busy),
      .pulse_mark (pulse_mark),
      .done       (done),
      .dropped    (dropped),
      .fsm_state  (fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic do_reset();
      reset     = 1'b1;
      start     = 1'b0;
      auto_en   = 1'b0;
      period    = 16'd0;
      amplitude = 12'd0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      exp_q.delete();
   endtask

   // ---------------- expected-value model ----------------
   function automatic logic [W-1:0] pack(input logic d, input logic b, input logic m, input int a);
      int c;
      c = (a > 4095) ? 4095 : a;
      return {d, b, m, c[11:0]};
   endfunction

   // Isolated pulse: 4 rise samples (step, 2*step, 3*step, amp) then
   // v -= v/16 until v/16 is zero, where the level drops to 0 with done.
   task automatic push_pulse(input int amp, output int n);
      int st;
      int lv;
      st = amp / 4;
      n = 0;
      for (int k = 1; k <= 3; k++) begin
         exp_q.push_back(pack(1'b0, 1'b1, k == 1, st * k));
         n++;
      end
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, amp));
      n++;
      lv = amp;
      forever begin
         if (lv / 16 == 0) begin
            exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 0));
            n++;
            break;
         end
         lv = lv - lv / 16;
         exp_q.push_back(pack(1'b0, 1'b1, 1'b0, lv));
         n++;
      end
   endtask

   task automatic push_idle(input int cnt);
      for (int k = 0; k < cnt; k++) exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 0));
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (adc_data !== 12'd0) begin
         errors++;
         $display("FAIL reset_adc got %0d expected 0", adc_data);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b expected 0", busy);
      end
      checks++;
      if (pulse_mark !== 1'b0) begin
         errors++;
         $display("FAIL reset_mark got %b expected 0", pulse_mark);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done got %b expected 0", done);
      end
      checks++;
      if (dropped !== 8'd0) begin
         errors++;
         $display("FAIL reset_dropped got %0d expected 0", dropped);
      end
      checks++;
      if (fsm_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state got %0d expected %0d", fsm_state, IDLE);
      end
   endtask

   task automatic test_single_pulse(input int amp, input string name);
      int n;
      int i;
      do_reset();
      push_pulse(amp, n);
      push_idle(3);
      amplitude = amp[11:0];
      start = 1'b1;
      i = 0;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         got = {done, busy, pulse_mark, adc_data};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL %s edge %0d got done=%b busy=%b mark=%b adc=%0d expected done=%b busy=%b mark=%b adc=%0d",
                     name, i, got[14], got[13], got[12], got[11:0], exp_v[14], exp_v[13], exp_v[12], exp_v[11:0]);
         end
         i++;
      end
      checks++;
      if (dropped !== 8'd0) begin
         errors++;
         $display("FAIL %s_dropped got %0d expected 0", name, dropped);
      end
   endtask

   task automatic test_reject_in_rise();
      int n;
      int i;
      do_reset();
      push_pulse(1000, n);
      push_idle(2);
      amplitude = 12'd1000;
      start = 1'b1;
      i = 0;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         i++;
         // A different amplitude on the rejected request would show up in
         // the waveform if it were wrongly accepted.
         start     = (i == 2);
         amplitude = (i == 2) ? 12'd500 : 12'd1000;
         got = {done, busy, pulse_mark, adc_data};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL reject edge %0d got done=%b busy=%b mark=%b adc=%0d expected done=%b busy=%b mark=%b adc=%0d",
                     i - 1, got[14], got[13], got[12], got[11:0], exp_v[14], exp_v[13], exp_v[12], exp_v[11:0]);
         end
      end
      checks++;
      if (dropped !== 8'd1) begin
         errors++;
         $display("FAIL reject_dropped got %0d expected 1", dropped);
      end
   endtask

   task automatic test_pileup();
      int i;
      int lv;
      do_reset();
      // First pulse 3000: step 750, two decay samples, then the second
      // request lands on edge 6 with the level held at 2638.
      exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 750));
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1500));
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 2250));
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 3000));
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 2813));
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 2638));
      exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 2638));
      for (int k = 1; k <= 3; k++) exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 2638 + 750 * k));
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 4095));
      lv = 4095;
      forever begin
         if (lv / 16 == 0) begin
            exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 0));
            break;
         end
         lv = lv - lv / 16;
         exp_q.push_back(pack(1'b0, 1'b1, 1'b0, lv));
      end
      push_idle(2);
      amplitude = 12'd3000;
      start = 1'b1;
      i = 0;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         i++;
         start = (i == 6);
         got = {done, busy, pulse_mark, adc_data};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL pileup edge %0d got done=%b busy=%b mark=%b adc=%0d expected done=%b busy=%b mark=%b adc=%0d",
                     i - 1, got[14], got[13], got[12], got[11:0], exp_v[14], exp_v[13], exp_v[12], exp_v[11:0]);
         end
      end
      checks++;
      if (dropped !== 8'd0) begin
         errors++;
         $display("FAIL pileup_dropped got %0d expected 0", dropped);
      end
   endtask

   task automatic test_auto_trigger();
      int n;
      int i;
      do_reset();
      for (int p = 0; p < 3; p++) begin
         push_pulse(200, n);
         push_idle(100 - n);
      end
      auto_en   = 1'b1;
      period    = 16'd100;
      amplitude = 12'd200;
      start     = 1'b1;   // coincides with the first auto-trigger
      i = 0;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         got = {done, busy, pulse_mark, adc_data};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL auto edge %0d got done=%b busy=%b mark=%b adc=%0d expected done=%b busy=%b mark=%b adc=%0d",
                     i, got[14], got[13], got[12], got[11:0], exp_v[14], exp_v[13], exp_v[12], exp_v[11:0]);
         end
         i++;
      end
      checks++;
      if (dropped !== 8'd0) begin
         errors++;
         $display("FAIL auto_coincident_dropped got %0d expected 0", dropped);
      end
      // period 0 with auto_en still high: no trigger at all.
      period = 16'd0;
      push_idle(150);
      i = 0;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         got = {done, busy, pulse_mark, adc_data};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL auto_period0 edge %0d got done=%b busy=%b mark=%b adc=%0d expected done=%b busy=%b mark=%b adc=%0d",
                     i, got[14], got[13], got[12], got[11:0], exp_v[14], exp_v[13], exp_v[12], exp_v[11:0]);
         end
         i++;
      end
      auto_en = 1'b0;
   endtask

   task automatic test_reset_mid_pulse();
      do_reset();
      amplitude = 12'd1000;
      start = 1'b1;
      @(posedge clk);   // accepted
      #1;
      @(posedge clk);   // rejected in RISE, dropped becomes 1
      #1;
      checks++;
      if (dropped !== 8'd1) begin
         errors++;
         $display("FAIL midreset_pre_dropped got %0d expected 1", dropped);
      end
      reset = 1'b1;     // start still high on the reset edge
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      checks++;
      if ({done, busy, pulse_mark, adc_data} !== pack(1'b0, 1'b0, 1'b0, 0)) begin
         errors++;
         $display("FAIL midreset_outputs got done=%b busy=%b mark=%b adc=%0d expected done=0 busy=0 mark=0 adc=0",
                  done, busy, pulse_mark, adc_data);
      end
      checks++;
      if (dropped !== 8'd0) begin
         errors++;
         $display("FAIL midreset_dropped got %0d expected 0", dropped);
      end
      push_idle(4);
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         got = {done, busy, pulse_mark, adc_data};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL midreset_after got done=%b busy=%b mark=%b adc=%0d expected idle zero",
                     got[14], got[13], got[12], got[11:0]);
         end
      end
   endtask

   task automatic test_dropped_saturation();
      do_reset();
      amplitude = 12'd0;
      start = 1'b1;     // held high: accepted in IDLE/DECAY, rejected in RISE
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (dropped !== 8'd3) begin
         errors++;
         $display("FAIL drop_first_rise got %0d expected 3", dropped);
      end
      repeat (400) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (dropped !== 8'd255) begin
         errors++;
         $display("FAIL drop_saturate got %0d expected 255", dropped);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL drop_busy got %b expected 1", busy);
      end
      start = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_pulse(1000, "pulse1000");
      test_single_pulse(0, "pulse_zero");
      test_single_pulse(4095, "pulse_full");
      test_single_pulse($urandom_range(1, 4095), "pulse_rand");
      test_reject_in_rise();
      test_pileup();
      test_auto_trigger();
      test_reset_mid_pulse();
      test_dropped_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
